// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Generates the 640x480@60 raster. A clock divider produces one pixel tick
//   every CLK_DIV system clocks. On each tick all pixel outputs load the decode
//   of the current (h, v) position together, and then the counters advance.
//   h and v always hold the *next* position to present.
//
// Ports
//   clk          system clock
//   resetn       asynchronous, active-low reset
//   pix_en       one-clk pulse: a new pixel is presented on the outputs
//   x, y         pixel column/row while active, else 0
//   active       presented pixel is inside the visible region
//   hsync, vsync active-low sync pulses
//   line_start   presented pixel is column 0 of a line
//   frame_start  presented pixel is (0,0)
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  // A 1-bit divider is kept even for CLK_DIV == 1 so the counter always exists;
  // its terminal value is then 0 and every edge is a tick.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             tick;

  logic       d_active;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       d_hsync;
  logic       d_vsync;
  logic       d_line_start;
  logic       d_frame_start;

  assign tick = (div_cnt == DIV_LAST);

  // Decode of the position about to be presented; only ever sampled on a tick.
  always_comb begin
    d_active      = (h < H_ACT_END) && (v < V_ACT_END);
    d_x           = d_active ? h : '0;
    d_y           = d_active ? v[8:0] : '0;
    d_hsync       = !((h >= HS_START) && (h < HS_END));
    d_vsync       = !((v >= VS_START) && (v < VS_END));
    d_line_start  = (h == '0);
    d_frame_start = (h == '0) && (v == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt     <= '0;
      h           <= '0;
      v           <= '0;
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en <= tick;
      if (tick) begin
        div_cnt     <= '0;
        x           <= d_x;
        y           <= d_y;
        active      <= d_active;
        hsync       <= d_hsync;
        vsync       <= d_vsync;
        line_start  <= d_line_start;
        frame_start <= d_frame_start;
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) v <= '0;
          else             v <= v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
//   dut   : default 640x480 timing, CLK_DIV=4 (reset, divider, one line,
//           start of the second line, mid-line asynchronous reset).
//   dut_s : shrunken raster (15x11 totals), CLK_DIV=1, used to cover whole
//           frames, vsync and frame_start recurrence within a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, resetn_s;
  logic       pix_en, active, hsync, vsync, ls, fs;
  logic [9:0] x;
  logic [8:0] y;
  logic       s_pix_en, s_active, s_hsync, s_vsync, s_ls, s_fs;
  logic [9:0] s_x;
  logic [8:0] s_y;

  vga_timing_gen dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .x(x), .y(y),
    .active(active), .hsync(hsync), .vsync(vsync),
    .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .resetn(resetn_s), .pix_en(s_pix_en), .x(s_x), .y(s_y),
    .active(s_active), .hsync(s_hsync), .vsync(s_vsync),
    .line_start(s_ls), .frame_start(s_fs)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int idx;
    int x, y, act, hs, vs, ls, fs;
  } vec_t;

  vec_t vecs[13];

  // Per-pulse bookkeeping for the default DUT.
  int pulse_idx;
  int last_gap;
  int bad_gap, hold_bad, xbad;
  int hs_low, act_cnt, ls_cnt;
  bit accum;
  bit timed_out;

  // Advance to the next pix_en pulse, sampling on falling edges.
  task automatic next_pulse();
    int edges;
    logic [9:0] px;
    logic pls;
    edges = 0;
    px  = x;
    pls = ls;
    do begin
      @(negedge clk);
      edges++;
      if (!pix_en && (x != px || ls != pls)) hold_bad++;
    end while (!pix_en && edges < 20);
    last_gap = edges;
    if (!pix_en) begin
      timed_out = 1'b1;
      chk("pulse_timeout", 0, 1);
      return;
    end
    pulse_idx++;
    if (pulse_idx > 0 && edges != 4) bad_gap++;
    if (accum && pulse_idx < 800) begin
      if (!hsync) hs_low++;
      if (active) act_cnt++;
      if (ls)     ls_cnt++;
      if (pulse_idx < 640 && int'(x) != pulse_idx) xbad++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pix_en"}, int'(pix_en), 0);
    chk({tag, "_x"},      int'(x), 0);
    chk({tag, "_y"},      int'(y), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_hsync"},  int'(hsync), 1);
    chk({tag, "_vsync"},  int'(vsync), 1);
    chk({tag, "_ls"},     int'(ls), 0);
    chk({tag, "_fs"},     int'(fs), 0);
  endtask

  initial begin
    //            idx   x    y  act hs vs ls fs
    vecs[0]  = '{  0,   0,   0, 1, 1, 1, 1, 1};
    vecs[1]  = '{  1,   1,   0, 1, 1, 1, 0, 0};
    vecs[2]  = '{  2,   2,   0, 1, 1, 1, 0, 0};
    vecs[3]  = '{639, 639,   0, 1, 1, 1, 0, 0};
    vecs[4]  = '{640,   0,   0, 0, 1, 1, 0, 0};
    vecs[5]  = '{655,   0,   0, 0, 1, 1, 0, 0};
    vecs[6]  = '{656,   0,   0, 0, 0, 1, 0, 0};
    vecs[7]  = '{751,   0,   0, 0, 0, 1, 0, 0};
    vecs[8]  = '{752,   0,   0, 0, 1, 1, 0, 0};
    vecs[9]  = '{799,   0,   0, 0, 1, 1, 0, 0};
    vecs[10] = '{800,   0,   1, 1, 1, 1, 1, 0};
    vecs[11] = '{801,   1,   1, 1, 1, 1, 0, 0};
    vecs[12] = '{923, 123,   1, 1, 1, 1, 0, 0};

    pulse_idx = -1; bad_gap = 0; hold_bad = 0; xbad = 0;
    hs_low = 0; act_cnt = 0; ls_cnt = 0; accum = 1'b1; timed_out = 1'b0;

    resetn = 1'b0;
    resetn_s = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_vals("reset");

    // Release between edges; first tick lands on the 4th rising edge.
    resetn = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk($sformatf("early_pix_en_e%0d", e), int'(pix_en), 0);
    end
    @(negedge clk);
    chk("first_tick_edge4", int'(pix_en), 1);
    pulse_idx = 0;
    if (active) act_cnt++;
    if (ls) ls_cnt++;
    if (!hsync) hs_low++;

    foreach (vecs[i]) begin
      while (pulse_idx < vecs[i].idx && !timed_out) next_pulse();
      chk($sformatf("v%0d_x", vecs[i].idx),   int'(x),      vecs[i].x);
      chk($sformatf("v%0d_y", vecs[i].idx),   int'(y),      vecs[i].y);
      chk($sformatf("v%0d_act", vecs[i].idx), int'(active), vecs[i].act);
      chk($sformatf("v%0d_hs", vecs[i].idx),  int'(hsync),  vecs[i].hs);
      chk($sformatf("v%0d_vs", vecs[i].idx),  int'(vsync),  vecs[i].vs);
      chk($sformatf("v%0d_ls", vecs[i].idx),  int'(ls),     vecs[i].ls);
      chk($sformatf("v%0d_fs", vecs[i].idx),  int'(fs),     vecs[i].fs);
      chk($sformatf("v%0d_pix_en", vecs[i].idx), int'(pix_en), 1);
    end

    chk("pulse_spacing_errors", bad_gap, 0);
    chk("hold_between_ticks_errors", hold_bad, 0);
    chk("x_ramp_errors", xbad, 0);
    chk("line0_hsync_low_pixels", hs_low, 96);
    chk("line0_active_pixels", act_cnt, 640);
    chk("line0_line_starts", ls_cnt, 1);

    // Mid-line asynchronous reset (line 1, pixel 123), asserted between edges.
    accum = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("held_reset");
    resetn = 1'b1;
    pulse_idx = -1;
    next_pulse();
    chk("post_reset_gap", last_gap, 4);
    chk("post_reset_x", int'(x), 0);
    chk("post_reset_y", int'(y), 0);
    chk("post_reset_active", int'(active), 1);
    chk("post_reset_ls", int'(ls), 1);
    chk("post_reset_fs", int'(fs), 1);
    next_pulse();
    chk("post_reset_x1", int'(x), 1);

    // Small raster, CLK_DIV=1: 15 pixels/line, 11 lines, 165 pixels/frame.
    begin
      int no_pix, vs_low, act_n, ls_n, ybad, ymax, xmax, hs_low_s;
      int fs_at[$];
      no_pix = 0; vs_low = 0; act_n = 0; ls_n = 0; ybad = 0;
      ymax = 0; xmax = 0; hs_low_s = 0;
      resetn_s = 1'b1;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (!s_pix_en) no_pix++;
        if (s_fs) fs_at.push_back(n);
        if (n == 0) begin
          chk("s_first_x", int'(s_x), 0);
          chk("s_first_active", int'(s_active), 1);
        end
        if (n < 165) begin
          if (!s_vsync) vs_low++;
          if (!s_hsync) hs_low_s++;
          if (s_active) act_n++;
          if (s_ls) ls_n++;
          if (!s_active && (s_x != 0 || s_y != 0)) ybad++;
          if (s_active && int'(s_y) > ymax) ymax = int'(s_y);
          if (s_active && int'(s_x) > xmax) xmax = int'(s_x);
        end
        // Pixel 7*15+3 = line 7, col 3: inside vsync, blanked.
        if (n == 108) begin
          chk("s_l7_vsync", int'(s_vsync), 0);
          chk("s_l7_y", int'(s_y), 0);
        end
      end
      chk("s_pix_en_gaps", no_pix, 0);
      chk("s_vsync_low_pixels", vs_low, 30);
      chk("s_hsync_low_pixels", hs_low_s, 33);
      chk("s_active_pixels", act_n, 48);
      chk("s_line_starts", ls_n, 11);
      chk("s_blank_xy_errors", ybad, 0);
      chk("s_y_max", ymax, 5);
      chk("s_x_max", xmax, 7);
      chk("s_frame_start_count", fs_at.size(), 3);
      if (fs_at.size() == 3) begin
        chk("s_frame_start_0", fs_at[0], 0);
        chk("s_frame_start_1", fs_at[1], 165);
        chk("s_frame_start_2", fs_at[2], 330);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
